bcd_scan_counter: RTL and testbench

- 4-digit BCD up/down counter with a time-multiplexed display scanner.
- Sits directly upstream of the BCD-to-7-segment decoder. Presents one BCD digit at a time on `bcd[3:0]`, wired to decoder inputs a=`bcd[3]`, b=`bcd[2]`, c=`bcd[1]`, d=`bcd[0]`.
- Presents the matching one-hot digit strobe on `digit_sel`, with optional leading-zero blanking.

---
 rtl/bcd_scan_counter.sv | 110 +++++++++++
 tb/tb_bcd_scan_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - 4-digit BCD up/down counter with multiplexed display scan
// Feeds one digit at a time to a BCD-to-7-segment decoder, with optional leading-zero blanking.
module bcd_scan_counter #(
   parameter int SCAN_DIV = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        up,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        lzb,
   output logic [15:0] count,
   output logic [3:0]  bcd,
   output logic [3:0]  digit_sel,
   output logic        carry
);

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

   logic [15:0] count_q, count_d;
   logic        carry_q, carry_d;
   logic [15:0] div_q;
   logic [1:0]  scan_idx;
   logic        ripple;
   logic [3:0]  digit;
   logic [3:0]  blank;

   // Ripple all four digits in one cycle; a carry/borrow out of thousands is a wrap.
   always_comb begin
      count_d = count_q;
      carry_d = 1'b0;
      ripple  = 1'b0;
      digit   = 4'd0;
      if (load) begin
         for (int i = 0; i < 4; i++) begin
            count_d[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
         end
      end else if (en) begin
         ripple = 1'b1;
         for (int i = 0; i < 4; i++) begin
            digit = count_q[4*i +: 4];
            if (ripple) begin
               if (up) begin
                  if (digit == 4'd9) begin
                     count_d[4*i +: 4] = 4'd0;
                  end else begin
                     count_d[4*i +: 4] = digit + 4'd1;
                     ripple = 1'b0;
                  end
               end else begin
                  if (digit == 4'd0) begin
                     count_d[4*i +: 4] = 4'd9;
                  end else begin
                     count_d[4*i +: 4] = digit - 4'd1;
                     ripple = 1'b0;
                  end
               end
            end
         end
         carry_d = ripple;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= 16'd0;
         carry_q  <= 1'b0;
         div_q    <= 16'd0;
         scan_idx <= 2'd0;
      end else begin
         count_q <= count_d;
         carry_q <= carry_d;
         if (div_q == DIV_LAST) begin
            div_q    <= 16'd0;
            scan_idx <= scan_idx + 2'd1;
         end else begin
            div_q <= div_q + 16'd1;
         end
      end
   end

   // A digit is blankable when it and everything above it are zero; units never is.
   assign blank[3] = (count_q[15:12] == 4'd0);
   assign blank[2] = blank[3] && (count_q[11:8] == 4'd0);
   assign blank[1] = blank[2] && (count_q[7:4] == 4'd0);
   assign blank[0] = 1'b0;

   always_comb begin
      bcd = count_q[3:0];
      case (scan_idx)
         2'd0: bcd = count_q[3:0];
         2'd1: bcd = count_q[7:4];
         2'd2: bcd = count_q[11:8];
         2'd3: bcd = count_q[15:12];
         default: bcd = count_q[3:0];
      endcase
   end

   always_comb begin
      digit_sel = 4'b0001 << scan_idx;
      if (lzb && blank[scan_idx]) begin
         digit_sel = 4'b0000;
      end
   end

   assign count = count_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - directed bench for bcd_scan_counter
// Decimal-integer reference model checked every cycle plus literal expectations.
module tb_bcd_scan_counter;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst, en, up, load, lzb;
   logic [15:0] load_val;
   logic [15:0] count;
   logic [3:0]  bcd, digit_sel;
   logic        carry;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk     = 1'b0;

   int m_val   = 0;
   int m_t     = 0;
   bit m_carry = 1'b0;

   bcd_scan_counter #(.SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .lzb(lzb), .count(count), .bcd(bcd), .digit_sel(digit_sel), .carry(carry)
   );

   always #5 clk = ~clk;

   function automatic int pow10(input int n);
      int r = 1;
      for (int k = 0; k < n; k++) r = r * 10;
      return r;
   endfunction

   function automatic int dec_digit(input int v, input int i);
      return (v / pow10(i)) % 10;
   endfunction

   function automatic int to_bcd(input int v);
      int r = 0;
      for (int i = 0; i < 4; i++) r = r + (dec_digit(v, i) << (4 * i));
      return r;
   endfunction

   function automatic int load_to_int(input logic [15:0] lv);
      int r = 0;
      int nib;
      for (int i = 0; i < 4; i++) begin
         nib = int'((lv >> (4 * i)) & 16'hF);
         if (nib <= 9) r = r + nib * pow10(i);
      end
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_val = 0; m_t = 0; m_carry = 1'b0;
      end else begin
         m_t = m_t + 1;
         if (load) begin
            m_val = load_to_int(load_val); m_carry = 1'b0;
         end else if (en) begin
            if (up) begin
               m_carry = (m_val == 9999); m_val = (m_val + 1) % 10000;
            end else begin
               m_carry = (m_val == 0); m_val = (m_val + 9999) % 10000;
            end
         end else begin
            m_carry = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      int idx;
      int sel;
      if (chk) begin
         idx = (m_t / SD) % 4;
         sel = (lzb && idx > 0 && m_val < pow10(idx)) ? 0 : (1 << idx);
         check("model_count", int'(count), to_bcd(m_val));
         check("model_bcd", int'(bcd), dec_digit(m_val, idx));
         check("model_sel", int'(digit_sel), sel);
         check("model_carry", int'(carry), int'(m_carry));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      load = 1'b1; load_val = v;
      tick();
      load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lzb = 1'b0; load_val = 16'h0;
      tick(2);
      rst = 1'b0;
      chk = 1'b1;
      check("rst_count", int'(count), 16'h0000);
      check("rst_sel", int'(digit_sel), 4'b0001);
      check("rst_bcd", int'(bcd), 0);
      check("rst_carry", int'(carry), 0);
      tick(4);
      check("scan_sel1", int'(digit_sel), 4'b0010);
      tick(4);
      check("scan_sel2", int'(digit_sel), 4'b0100);
      tick(4);
      check("scan_sel3", int'(digit_sel), 4'b1000);
      tick(4);
      check("scan_wrap", int'(digit_sel), 4'b0001);

      do_load(16'h9998);
      check("ld_9998", int'(count), 16'h9998);
      en = 1'b1; up = 1'b1;
      tick(); check("up_9999", int'(count), 16'h9999); check("up_c0", int'(carry), 0);
      tick(); check("up_0000", int'(count), 16'h0000); check("up_c1", int'(carry), 1);
      tick(); check("up_0001", int'(count), 16'h0001); check("up_c2", int'(carry), 0);
      en = 1'b0;

      do_load(16'h0000);
      en = 1'b1; up = 1'b0;
      tick(); check("dn_9999", int'(count), 16'h9999); check("dn_c1", int'(carry), 1);
      en = 1'b0;
      tick(); check("dn_c0", int'(carry), 0);
      do_load(16'h1000);
      en = 1'b1; up = 1'b0;
      tick(); check("dn_0999", int'(count), 16'h0999); check("dn_c2", int'(carry), 0);

      load = 1'b1; load_val = 16'h12AF; up = 1'b1;
      tick(); check("ld_prio", int'(count), 16'h1200); check("ld_c", int'(carry), 0);
      load = 1'b0; en = 1'b0;
      do_load(16'hFFFF); check("ld_ffff", int'(count), 16'h0000);
      do_load(16'h9A9B); check("ld_9a9b", int'(count), 16'h9090);

      do_load(16'h9999);
      en = 1'b1;
      up = 1'b1; tick(); check("bb_c1", int'(carry), 1);
      up = 1'b0; tick(); check("bb_c2", int'(carry), 1);
      up = 1'b1; tick(); check("bb_c3", int'(carry), 1);
      check("bb_cnt", int'(count), 16'h0000);
      en = 1'b0;

      rst = 1'b1; tick(); rst = 1'b0;
      do_load(16'h0042);
      lzb = 1'b1;
      check("lzb_u_sel", int'(digit_sel), 4'b0001); check("lzb_u_bcd", int'(bcd), 2);
      tick(3);
      check("lzb_t_sel", int'(digit_sel), 4'b0010); check("lzb_t_bcd", int'(bcd), 4);
      tick(4);
      check("lzb_h_sel", int'(digit_sel), 4'b0000); check("lzb_h_bcd", int'(bcd), 0);
      tick(4);
      check("lzb_k_sel", int'(digit_sel), 4'b0000);
      tick(4);
      check("lzb_u2_sel", int'(digit_sel), 4'b0001);
      lzb = 1'b0;
      tick(8);
      check("nolzb_h_sel", int'(digit_sel), 4'b0100); check("nolzb_h_bcd", int'(bcd), 0);
      tick(4);
      check("nolzb_k_sel", int'(digit_sel), 4'b1000);

      rst = 1'b1; tick(); rst = 1'b0;
      lzb = 1'b1;
      check("lzb_zero_sel", int'(digit_sel), 4'b0001);
      tick(4);
      check("lzb_zero_t", int'(digit_sel), 4'b0000);
      lzb = 1'b0;

      rst = 1'b1; tick(); rst = 1'b0;
      do_load(16'h0537);
      tick(7);
      check("mid_sel", int'(digit_sel), 4'b0100); check("mid_bcd", int'(bcd), 5);
      en = 1'b1; up = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; en = 1'b0;
      check("mid_rst_cnt", int'(count), 16'h0000);
      check("mid_rst_sel", int'(digit_sel), 4'b0001);
      tick(3);
      check("mid_hold", int'(digit_sel), 4'b0001);
      tick();
      check("mid_adv", int'(digit_sel), 4'b0010);

      for (int k = 0; k < 200; k++) begin
         en   = 1'($urandom_range(0, 1));
         up   = 1'($urandom_range(0, 1));
         lzb  = 1'($urandom_range(0, 1));
         load = ($urandom_range(0, 15) == 0);
         load_val = 16'($urandom);
         tick();
      end
      load = 1'b0; en = 1'b0;
      tick();

      chk = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
